// File: rtl/exc_pkg.sv
// Shared types and cause encoding for the exception/interrupt controller.
//   state_e   : handshake FSM states
//   EC_*      : EStatus cause codes (1 and 2 kept compatible with the old single-IRQ encoding)
//   irq_code  : cause code for external channel ch
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        HANDLER = 2'd2
    } state_e;

    localparam int unsigned EC_NONE     = 0;
    localparam int unsigned EC_IRQ0     = 1;
    localparam int unsigned EC_NOTINSTR = 2;
    localparam int unsigned EC_IRQ_BASE = 2;

    // Channel 0 keeps the legacy code 1; channel i >= 1 sits above NotAnInstr.
    function automatic int unsigned irq_code(input int unsigned ch);
        return (ch == 0) ? EC_IRQ0 : EC_IRQ_BASE + ch;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational find-first-set over the request vector; lowest index wins.
//   req   in  N_IRQ  request lines (pending & ~mask)
//   valid out 1      any request present
//   idx   out IDX_W  index of the lowest set request
module irq_prio_enc #(
    parameter  int unsigned N_IRQ = 4,
    localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic [N_IRQ-1:0] req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/exc_irq_ctrl.sv
// Multi-channel exception/interrupt controller for the LEGv8 pipeline.
// Latches rising edges of ExtIRQ into pending, picks one cause by fixed
// priority (NotAnInstr first, then lowest unmasked channel) and runs the
// Exc / ExcAck / ERet handshake with the core.
//   clk, reset  clock and synchronous active-high reset
//   ExtIRQ      external IRQ levels (edge-captured)
//   IrqMask     1 = channel masked (still latched, not taken)
//   NotAnInstr  decoder flag for an invalid opcode
//   ExcAck      core has vectored to the handler
//   ERet        handler is returning
//   Exc         exception request (high while in TAKE)
//   EStatus     cause code, held from Exc until ERet
//   ExtIAck     one-cycle acknowledge to the serviced channel
//   Busy        high while in TAKE or HANDLER
//   DblFault    sticky: NotAnInstr seen while busy
module exc_irq_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned N_IRQ     = 4,
    parameter int unsigned ESTATUS_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_IRQ-1:0]     ExtIRQ,
    input  logic [N_IRQ-1:0]     IrqMask,
    input  logic                 NotAnInstr,
    input  logic                 ExcAck,
    input  logic                 ERet,
    output logic                 Exc,
    output logic [ESTATUS_W-1:0] EStatus,
    output logic [N_IRQ-1:0]     ExtIAck,
    output logic                 Busy,
    output logic                 DblFault
);

    localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    state_e               state_q,   state_d;
    logic [N_IRQ-1:0]     irq_q,     irq_d;
    logic [N_IRQ-1:0]     pending_q, pending_d;
    logic [ESTATUS_W-1:0] cause_q,   cause_d;
    logic [IDX_W-1:0]     ch_q,      ch_d;
    logic                 is_irq_q,  is_irq_d;
    logic                 exc_q,     exc_d;
    logic [N_IRQ-1:0]     ack_q,     ack_d;
    logic                 busy_q,    busy_d;
    logic                 dbl_q,     dbl_d;

    logic                 win_valid;
    logic [IDX_W-1:0]     win_idx;

    irq_prio_enc #(
        .N_IRQ (N_IRQ)
    ) u_prio (
        .req   (pending_q & ~IrqMask),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // Next-state, cause latching and ack-pulse generation.
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        ch_d     = ch_q;
        is_irq_d = is_irq_q;
        ack_d    = '0;
        irq_d    = ExtIRQ;
        // The acknowledge pulse clears; a fresh edge in the same cycle wins.
        pending_d = (pending_q & ~ack_q) | (ExtIRQ & ~irq_q);
        dbl_d     = dbl_q | (NotAnInstr && (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                if (NotAnInstr) begin
                    cause_d  = ESTATUS_W'(EC_NOTINSTR);
                    is_irq_d = 1'b0;
                    state_d  = TAKE;
                end else if (win_valid) begin
                    cause_d  = ESTATUS_W'(irq_code(32'(win_idx)));
                    ch_d     = win_idx;
                    is_irq_d = 1'b1;
                    state_d  = TAKE;
                end
            end
            TAKE: begin
                if (ExcAck) begin
                    if (is_irq_q) begin
                        ack_d = N_IRQ'(1) << ch_q;
                    end
                    state_d = HANDLER;
                end
            end
            HANDLER: begin
                if (ERet) begin
                    cause_d = ESTATUS_W'(EC_NONE);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        exc_d  = (state_d == TAKE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            cause_q   <= '0;
            ch_q      <= '0;
            is_irq_q  <= 1'b0;
            exc_q     <= 1'b0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
            dbl_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            pending_q <= pending_d;
            cause_q   <= cause_d;
            ch_q      <= ch_d;
            is_irq_q  <= is_irq_d;
            exc_q     <= exc_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            dbl_q     <= dbl_d;
        end
    end

    assign Exc      = exc_q;
    assign EStatus  = cause_q;
    assign ExtIAck  = ack_q;
    assign Busy     = busy_q;
    assign DblFault = dbl_q;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Self-checking bench for exc_irq_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the controller.
module tb_exc_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ExtIRQ;
    logic [3:0] IrqMask;
    logic       NotAnInstr;
    logic       ExcAck;
    logic       ERet;
    logic       Exc;
    logic [3:0] EStatus;
    logic [3:0] ExtIAck;
    logic       Busy;
    logic       DblFault;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    exc_irq_ctrl #(.N_IRQ(4), .ESTATUS_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .ExtIRQ     (ExtIRQ),
        .IrqMask    (IrqMask),
        .NotAnInstr (NotAnInstr),
        .ExcAck     (ExcAck),
        .ERet       (ERet),
        .Exc        (Exc),
        .EStatus    (EStatus),
        .ExtIAck    (ExtIAck),
        .Busy       (Busy),
        .DblFault   (DblFault)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase: 0 waiting for a cause, 1 requesting, 2 in handler
    int  m_phase;
    bit  m_prev [4];
    bit  m_pend [4];
    bit  m_ack  [4];
    int  m_cause;
    int  m_ch;
    bit  m_is_irq;
    bit  m_dbl;

    always @(posedge clk) begin
        bit nxt_pend [4];
        bit nxt_ack  [4];
        int win;
        if (reset) begin
            m_phase = 0; m_cause = 0; m_ch = 0; m_is_irq = 0; m_dbl = 0;
            for (int i = 0; i < 4; i++) begin
                m_prev[i] = 0; m_pend[i] = 0; m_ack[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                nxt_ack[i]  = 0;
                nxt_pend[i] = (m_pend[i] && !m_ack[i]) || (ExtIRQ[i] && !m_prev[i]);
            end
            if (NotAnInstr && m_phase != 0) m_dbl = 1;
            if (m_phase == 0) begin
                win = -1;
                for (int i = 3; i >= 0; i--)
                    if (m_pend[i] && !IrqMask[i]) win = i;
                if (NotAnInstr) begin
                    m_cause = 2; m_is_irq = 0; m_phase = 1;
                end else if (win >= 0) begin
                    m_cause = (win == 0) ? 1 : 2 + win;
                    m_ch = win; m_is_irq = 1; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (ExcAck) begin
                    if (m_is_irq) nxt_ack[m_ch] = 1;
                    m_phase = 2;
                end
            end else begin
                if (ERet) begin
                    m_cause = 0; m_phase = 0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = nxt_pend[i];
                m_ack[i]  = nxt_ack[i];
                m_prev[i] = ExtIRQ[i];
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            int exp_ack;
            exp_ack = 0;
            for (int i = 0; i < 4; i++) if (m_ack[i]) exp_ack |= (1 << i);
            chk("model_Exc",      int'(Exc),      int'(m_phase == 1));
            chk("model_EStatus",  int'(EStatus),  m_cause);
            chk("model_ExtIAck",  int'(ExtIAck),  exp_ack);
            chk("model_Busy",     int'(Busy),     int'(m_phase != 0));
            chk("model_DblFault", int'(DblFault), int'(m_dbl));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_negedge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ExtIRQ = '0; IrqMask = '0; NotAnInstr = 0; ExcAck = 0; ERet = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        next_cycle();
        next_cycle();
        reset = 0;
    endtask

    task automatic check_all_zero(input string name);
        at_negedge();
        chk({name, "_Exc"},      int'(Exc),      0);
        chk({name, "_EStatus"},  int'(EStatus),  0);
        chk({name, "_ExtIAck"},  int'(ExtIAck),  0);
        chk({name, "_Busy"},     int'(Busy),     0);
        chk({name, "_DblFault"}, int'(DblFault), 0);
    endtask

    initial begin
        reset = 1;
        ExtIRQ = 4'hF; IrqMask = '0; NotAnInstr = 0; ExcAck = 0; ERet = 0;
        next_cycle();
        cmp_en = 1'b1;
        next_cycle();

        // 1) reset with all lines high, then edges seen after release
        check_all_zero("t1_reset");
        reset = 0;
        next_cycle();
        at_negedge(); chk("t1_exc_plus1", int'(Exc), 0);
        next_cycle();
        at_negedge();
        chk("t1_exc_plus2", int'(Exc), 1);
        chk("t1_estatus", int'(EStatus), 1);

        // 2) channel 2 service
        do_reset();
        ExtIRQ = 4'b0100;
        next_cycle();
        ExtIRQ = 4'b0000;
        next_cycle();
        at_negedge();
        chk("t2_exc", int'(Exc), 1);
        chk("t2_estatus", int'(EStatus), 4);
        ExcAck = 1;
        next_cycle();
        ExcAck = 0;
        at_negedge();
        chk("t2_iack", int'(ExtIAck), 4);
        chk("t2_busy", int'(Busy), 1);
        chk("t2_exc_low", int'(Exc), 0);
        next_cycle();
        at_negedge(); chk("t2_iack_gone", int'(ExtIAck), 0);
        ERet = 1;
        next_cycle();
        ERet = 0;
        at_negedge();
        chk("t2_eret_estatus", int'(EStatus), 0);
        chk("t2_eret_busy", int'(Busy), 0);

        // 3) NotAnInstr beats a simultaneous IRQ0 edge
        do_reset();
        NotAnInstr = 1; ExtIRQ = 4'b0001;
        next_cycle();
        NotAnInstr = 0;
        at_negedge();
        chk("t3_first_cause", int'(EStatus), 2);
        ExcAck = 1;
        next_cycle();
        ExcAck = 0;
        at_negedge(); chk("t3_no_iack", int'(ExtIAck), 0);
        ERet = 1;
        next_cycle();
        ERet = 0;
        at_negedge(); chk("t3_idle_exc", int'(Exc), 0);
        next_cycle();
        at_negedge();
        chk("t3_second_exc", int'(Exc), 1);
        chk("t3_second_cause", int'(EStatus), 1);

        // 4) masked channel stays pending until unmasked
        do_reset();
        IrqMask = 4'b0010; ExtIRQ = 4'b0010;
        next_cycle();
        ExtIRQ = 4'b0000;
        repeat (20) next_cycle();
        at_negedge(); chk("t4_masked", int'(Exc), 0);
        IrqMask = 4'b0000;
        next_cycle();
        at_negedge();
        chk("t4_unmasked_exc", int'(Exc), 1);
        chk("t4_unmasked_cause", int'(EStatus), 3);

        // 5) double fault, ERet ignored in TAKE, reset in HANDLER
        do_reset();
        NotAnInstr = 1;
        next_cycle();
        NotAnInstr = 0;
        ERet = 1;
        next_cycle();
        ERet = 0;
        at_negedge(); chk("t5_eret_in_take", int'(Exc), 1);
        ExcAck = 1;
        next_cycle();
        ExcAck = 0;
        at_negedge(); chk("t5_no_dbl_yet", int'(DblFault), 0);
        NotAnInstr = 1;
        next_cycle();
        NotAnInstr = 0;
        at_negedge(); chk("t5_dbl_set", int'(DblFault), 1);
        repeat (3) next_cycle();
        at_negedge(); chk("t5_dbl_sticky", int'(DblFault), 1);
        reset = 1;
        next_cycle();
        check_all_zero("t5_reset");
        reset = 0;

        // 6) re-edge during the acknowledge pulse keeps the channel pending
        do_reset();
        ExtIRQ = 4'b1000;
        next_cycle();
        ExtIRQ = 4'b0000;
        next_cycle();
        at_negedge(); chk("t6_first_cause", int'(EStatus), 5);
        ExcAck = 1;
        next_cycle();
        ExcAck = 0;
        at_negedge(); chk("t6_iack", int'(ExtIAck), 8);
        ExtIRQ = 4'b1000;
        next_cycle();
        ExtIRQ = 4'b0000;
        ERet = 1;
        next_cycle();
        ERet = 0;
        next_cycle();
        at_negedge();
        chk("t6_second_exc", int'(Exc), 1);
        chk("t6_second_cause", int'(EStatus), 5);

        // Randomized traffic checked against the model every cycle.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            reset      = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) ExtIRQ[i] = ~ExtIRQ[i];
            if ($urandom_range(0, 19) == 0) IrqMask = 4'($urandom_range(0, 15));
            NotAnInstr = ($urandom_range(0, 15) == 0);
            ExcAck     = ($urandom_range(0, 3) == 0);
            ERet       = ($urandom_range(0, 3) == 0);
            next_cycle();
        end

        reset = 0;
        idle_inputs();
        next_cycle();
        at_negedge();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
